// File: rtl/fc_argmax_classifier.sv
// Serial signed argmax over a buffered vector of logits with a valid/ready result.
// Optional top1-minus-top2 margin tracking is enabled by defining FC_ARGMAX_MARGIN_EN.
module fc_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W*NUM_CLASSES-1:0] logits,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              class_idx,
  output logic [DATA_W-1:0]             max_logit,
  output logic [DATA_W-1:0]             margin,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t state_reg;
  state_t state_next;

  logic [DATA_W-1:0] logit_in [NUM_CLASSES];
  logic [DATA_W-1:0] buf_reg  [NUM_CLASSES];

  logic [IDX_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] best_reg;
  logic [IDX_W-1:0]  best_idx_reg;

  logic [DATA_W-1:0] best_next;
  logic [IDX_W-1:0]  best_idx_next;
  logic [DATA_W-1:0] margin_next;
  logic [DATA_W-1:0] cur_val;
  logic              cur_gt_best;

  logic [IDX_W-1:0]  class_idx_reg;
  logic [DATA_W-1:0] max_logit_reg;
  logic [DATA_W-1:0] margin_reg;

  logic accept;
  logic last_elem;

  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
      assign logit_in[gi] = logits[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign accept    = in_valid && (state_reg == IDLE);
  assign last_elem = (state_reg == SCAN) && (cnt_reg == LAST_IDX);

  // The whole vector is captured once so upstream is free after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        buf_reg[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        buf_reg[i] <= logit_in[i];
      end
    end
  end

  assign cur_val     = buf_reg[cnt_reg];
  assign cur_gt_best = $signed(cur_val) > $signed(best_reg);

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    if (cur_gt_best) begin
      best_next     = cur_val;
      best_idx_next = cnt_reg;
    end
  end

`ifdef FC_ARGMAX_MARGIN_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] second_reg;
  logic [DATA_W-1:0] second_next;

  // An element equal to the best still promotes into second place.
  always_comb begin
    second_next = second_reg;
    if (cur_gt_best) begin
      second_next = best_reg;
    end else if ($signed(cur_val) > $signed(second_reg)) begin
      second_next = cur_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      second_reg <= '0;
    end else if (accept) begin
      second_reg <= MOST_NEG;
    end else if (state_reg == SCAN) begin
      second_reg <= second_next;
    end
  end

  assign margin_next = best_next - second_next;
`else
  assign margin_next = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
    end else if (accept) begin
      cnt_reg      <= IDX_W'(1);
      best_reg     <= logit_in[0];
      best_idx_reg <= '0;
    end else if (state_reg == SCAN) begin
      cnt_reg      <= cnt_reg + IDX_W'(1);
      best_reg     <= best_next;
      best_idx_reg <= best_idx_next;
    end
  end

  // Result registers hold their value until the next scan completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_idx_reg <= '0;
      max_logit_reg <= '0;
      margin_reg    <= '0;
    end else if (last_elem) begin
      class_idx_reg <= best_idx_next;
      max_logit_reg <= best_next;
      margin_reg    <= margin_next;
    end
  end

  assign class_idx = class_idx_reg;
  assign max_logit = max_logit_reg;
  assign margin    = margin_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (cnt_reg == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/fc_argmax_classifier.md
Name: fc_argmax_classifier

Overview:
Final classification stage directly downstream of the fully connected layer. It takes the 10 flattened 16-bit logits and scans them serially, one per cycle, for the signed maximum. It returns the winning class index and logit value over a valid/ready handshake. This gives the inference pipeline a single registered "predicted digit" result.

Parameters:
NUM_CLASSES, 10, number of logits per input vector (must be >= 2)
DATA_W, 16, logit width; two's-complement signed
IDX_W, 4, class index width (must satisfy 2^IDX_W >= NUM_CLASSES)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  logits vector valid
in_ready  output  1  block can accept a vector
logits  input  DATA_W*NUM_CLASSES  flattened logits; class k at [k*DATA_W +: DATA_W]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
class_idx  output  IDX_W  index of maximum logit
max_logit  output  DATA_W  value of maximum logit
margin  output  DATA_W  unsigned top1 minus top2; zero when feature compiled out
busy  output  1  high in SCAN or DONE

Behaviour:
- Reset (rst=1, async): state=IDLE; in_ready=1; out_valid=0; busy=0; class_idx=0; max_logit=0; margin=0; internal logit buffer, counter and best/second registers cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register the whole logits bus, best_val=logit[0], best_idx=0, cnt=1, go to SCAN.
  - The input bus is not sampled again until the next accept, so upstream may change it freely after the handshake.
- SCAN:
  - in_ready=0.
  - Each cycle, compare buffered logit[cnt] with best_val, signed. Strictly greater replaces best; ties keep the lower index.
  - cnt increments each cycle. On the cycle processing cnt==NUM_CLASSES-1, load class_idx, max_logit and margin with the final values, assert out_valid, and go to DONE.
- DONE:
  - in_ready=0, out_valid=1. Outputs are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0 on the next edge, go to IDLE. in_ready=1 in the following cycle; there is no same-cycle re-accept.
- Latency: out_valid rises exactly NUM_CLASSES-1 clock edges after the accepting edge (9 by default). Throughput is one vector per NUM_CLASSES+1 cycles with out_ready held high.
- class_idx, max_logit and margin keep their last value after the output handshake until the next result. They are meaningful only while out_valid=1.
- in_valid during SCAN or DONE is ignored; the vector is not captured.
- Reset mid-SCAN or mid-DONE aborts immediately: the partial result is discarded and no out_valid pulse follows.
- Compare arithmetic is full-width DATA_W signed, with no saturation or truncation.

Optional Feature:
- Macro: FC_ARGMAX_MARGIN_EN.
- Defined:
  - Track second_val, initialised to the most-negative value (1 followed by zeros) at accept.
  - Per element: if new>best then second=best, best=new; else if new>second then second=new. An element equal to best therefore sets second=best.
  - At DONE, margin=best_val-second_val as unsigned DATA_W (range 0..2^DATA_W-1).
- Not defined: no second_val logic is generated; margin is tied to 0.
- class_idx, max_logit and timing are identical in both builds.

Test Plan:
1. Tie, lower index wins: logits = {5,-3,100,7,100,0,0,0,0,1} (idx0 first) accepted at edge T -> out_valid at edge T+9, class_idx=2, max_logit=100 (0x0064), margin=0 with macro.
2. All negative: logits = -1,-2,...,-10 -> class_idx=0, max_logit=0xFFFF; margin=1 with macro, 0 without.
3. Extremes: idx9=0x7FFF, all others 0x8000 -> class_idx=9, max_logit=0x7FFF; margin=0xFFFF with macro.
4. Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and a changing logits bus -> outputs stable, in_ready=0, nothing captured; after the handshake, in_ready=1 one cycle later.
5. Reset mid-scan: assert rst 4 cycles after accept -> out_valid never rises, all outputs 0; after release in_ready=1, and a new vector {0,...,0,9 at idx3} yields class_idx=3.
6. Back-to-back: two vectors, out_ready=1 constant -> results in order, second accept exactly 2 cycles after the first result's out_valid edge.
